vga_timing_checker: RTL

Receive-side counterpart of the VGA timing generator. It samples hsync/vsync/hblnk/vblnk from a video timing stream and recovers the pixel and line counters (hcount_rx, vcount_rx). It checks every line and frame against the expected 800x600@60 VESA geometry and runs a lock state machine. It sits on the display/capture path, downstream of a timing source, and is also used as a self-check monitor on the generator's outputs.

---
 rtl/vga_timing_defs_pkg.sv | 36 +++
 rtl/vga_edge_det.sv | 40 ++++
 rtl/vga_timing_checker.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_defs_pkg.sv
// Shared 800x600@60 timing constants, lock-FSM encodings and small helpers
// used by the VGA timing checker (and the matching generator).
package vga_timing_defs;

    localparam int unsigned VGA_H_TOTAL      = 1056;
    localparam int unsigned VGA_H_ACTIVE     = 800;
    localparam int unsigned VGA_H_SYNC_START = 840;
    localparam int unsigned VGA_V_TOTAL      = 628;
    localparam int unsigned VGA_V_ACTIVE     = 600;
    localparam int unsigned VGA_V_SYNC_START = 601;
    localparam int unsigned VGA_LOCK_FRAMES  = 3;
    localparam int unsigned VGA_TIMEOUT      = 2112;

    // Bit positions inside the sampled {hsync, vsync, hblnk, vblnk} vector
    localparam int unsigned IDX_VBLNK = 0;
    localparam int unsigned IDX_HBLNK = 1;
    localparam int unsigned IDX_VSYNC = 2;
    localparam int unsigned IDX_HSYNC = 3;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } lock_state_e;

    // Increment that sticks at the all-ones value of an 11-bit counter
    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : (v + 11'd1);
    endfunction

    // Increment that sticks at the all-ones value of an 8-bit counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Registers a vector of timing inputs once and reports per-bit rising and
// falling edges between the current and the previous sample.
module vga_edge_det #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s1_d;
    logic [W-1:0] s2_q;
    logic [W-1:0] s2_d;

    // s1 captures the raw inputs, s2 keeps the sample one cycle older
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // sample pipeline with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= {W{1'b0}};
            s2_q <= {W{1'b0}};
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q    = s1_q;
    assign rise = s1_q & ~s2_q;
    assign fall = ~s1_q & s2_q;

endmodule

// File: rtl/vga_timing_checker.sv
// Receive-side VGA timing monitor: rebuilds hcount/vcount from the blanking
// edges, checks every line/frame against the expected geometry and runs a
// SEARCH/ACQUIRE/LOCKED state machine with a lost-signal timeout.
module vga_timing_checker
    import vga_timing_defs::*;
#(
    parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
    parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
    parameter int unsigned H_SYNC_START = VGA_H_SYNC_START,
    parameter int unsigned V_TOTAL      = VGA_V_TOTAL,
    parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
    parameter int unsigned V_SYNC_START = VGA_V_SYNC_START,
    parameter int unsigned LOCK_FRAMES  = VGA_LOCK_FRAMES,
    parameter int unsigned TIMEOUT      = VGA_TIMEOUT
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblnk,
    input  logic        vblnk,
    output logic [10:0] hcount_rx,
    output logic [10:0] vcount_rx,
    output logic        active,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_frames
);

    // Expected pre-update counter values at each timing event
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] H_SYNC_PRE = 11'(H_SYNC_START - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
    localparam logic [10:0] V_SYNC_PRE = 11'(V_SYNC_START - 1);
    localparam logic [7:0]  LOCK_CNT   = 8'(LOCK_FRAMES);
    localparam logic [15:0] TO_LIMIT   = 16'(TIMEOUT);

    logic [3:0]  samp_s;
    logic [3:0]  rise_s;
    logic [3:0]  fall_s;
    logic        ls_s;
    logic        fb_s;
    logic        err_now_s;
    logic        frame_bad_s;
    logic        to_hit_s;
    logic [7:0]  good_inc_s;
    logic        unused_ok_s;

    logic [10:0] hcount_q,      hcount_d;
    logic [10:0] vcount_q,      vcount_d;
    logic        active_q,      active_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_err_q,   frame_err_d;
    logic [15:0] to_q,          to_d;
    logic [7:0]  good_q,        good_d;
    logic [7:0]  err_frames_q,  err_frames_d;
    logic        locked_q,      locked_d;
    lock_state_e state_q,       state_d;

    vga_edge_det #(.W(4)) u_edge (
        .clk   (pclk),
        .rst_n (rst_n),
        .d     ({hsync, vsync, hblnk, vblnk}),
        .q     (samp_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Sync falling edges and sampled sync levels carry no timing information here
    assign unused_ok_s = ^{fall_s[IDX_HSYNC], fall_s[IDX_VSYNC],
                           samp_s[IDX_HSYNC], samp_s[IDX_VSYNC]};

    // Event decode and geometry checks against the pre-update counters
    always_comb begin
        ls_s        = fall_s[IDX_HBLNK];
        fb_s        = fall_s[IDX_VBLNK];
        err_now_s   = (ls_s              & (hcount_q != H_LAST))
                    | (rise_s[IDX_HBLNK] & (hcount_q != H_ACT_LAST))
                    | (rise_s[IDX_HSYNC] & (hcount_q != H_SYNC_PRE))
                    | (rise_s[IDX_VBLNK] & (vcount_q != V_ACT_LAST))
                    | (rise_s[IDX_VSYNC] & (vcount_q != V_SYNC_PRE))
                    | (fb_s              & (vcount_q != V_LAST));
        frame_bad_s = frame_err_q | err_now_s;
        to_hit_s    = (to_q == TO_LIMIT);
        good_inc_s  = sat_inc8(good_q);
    end

    // Recovered counters, active flag, frame pulse, error flag and timeout
    always_comb begin
        hcount_d      = ls_s ? 11'd0 : sat_inc11(hcount_q);
        vcount_d      = vcount_q;
        if (fb_s) begin
            vcount_d = 11'd0;
        end else if (ls_s) begin
            vcount_d = sat_inc11(vcount_q);
        end else begin
            vcount_d = vcount_q;
        end
        active_d      = ~(samp_s[IDX_HBLNK] | samp_s[IDX_VBLNK]);
        frame_start_d = fb_s;
        frame_err_d   = fb_s ? 1'b0 : frame_bad_s;
        // counter parks at the limit until the next line start
        to_d          = ls_s ? 16'd0 : (to_hit_s ? to_q : (to_q + 16'd1));
    end

    // Lock state machine; timeout overrides any same-cycle frame boundary
    always_comb begin
        state_d      = state_q;
        good_d       = good_q;
        err_frames_d = err_frames_q;
        if (to_hit_s) begin
            state_d = SEARCH;
            good_d  = 8'd0;
        end else if (fb_s) begin
            case (state_q)
                SEARCH: begin
                    state_d = ACQUIRE;
                    good_d  = 8'd0;
                end
                ACQUIRE: begin
                    if (frame_bad_s) begin
                        good_d = 8'd0;
                    end else begin
                        good_d  = good_inc_s;
                        state_d = (good_inc_s >= LOCK_CNT) ? LOCKED : ACQUIRE;
                    end
                end
                LOCKED: begin
                    if (frame_bad_s) begin
                        state_d      = ACQUIRE;
                        good_d       = 8'd0;
                        err_frames_d = sat_inc8(err_frames_q);
                    end else begin
                        state_d = LOCKED;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    good_d  = 8'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == LOCKED);
    end

    // All state registers with synchronous active-low reset
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 11'd0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_err_q   <= 1'b0;
            to_q          <= 16'd0;
            good_q        <= 8'd0;
            err_frames_q  <= 8'd0;
            locked_q      <= 1'b0;
            state_q       <= SEARCH;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            frame_err_q   <= frame_err_d;
            to_q          <= to_d;
            good_q        <= good_d;
            err_frames_q  <= err_frames_d;
            locked_q      <= locked_d;
            state_q       <= state_d;
        end
    end

    assign hcount_rx   = hcount_q;
    assign vcount_rx   = vcount_q;
    assign active      = active_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign err_frames  = err_frames_q;

endmodule
